// File: rtl/clk_enable_gen.sv
// clk_enable_gen: multi-channel fractional clock-enable generator with apply-aligned phase and lock flag.
// Optional per-channel phase offsets when CLK_ENABLE_GEN_PHASE_EN is defined.
module clk_enable_gen #(
  parameter int NUM_CH = 4,
  parameter int ACC_W = 32,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic              cfg_sel,
  input  logic [ACC_W-1:0]  cfg_data,
  input  logic              cfg_apply,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);
  localparam int CW = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(LOCK_CYCLES - 1);
  typedef enum logic {WAIT, LOCKED} state_t;
  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic locked_next;
  always_comb begin
    state_next = cfg_apply ? WAIT : (state == WAIT && cnt == LAST) ? LOCKED : state;
    cnt_next = cfg_apply ? '0 : (state == WAIT && cnt != LAST) ? cnt + 1'b1 : cnt;
    locked_next = state_next == LOCKED;
  end
  always_ff @(posedge refclk)
    if (!rst_n) begin
      state <= WAIT;
      cnt <= '0;
    end else begin
      state <= state_next;
      cnt <= cnt_next;
    end
  assign locked = state == LOCKED;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] shadow_inc, active_inc, acc, load;
    logic [ACC_W:0] sum;
    logic hit, ce_q;
    assign hit = cfg_wr && cfg_ch == 4'(i);
    assign sum = {1'b0, acc} + {1'b0, active_inc};
`ifdef CLK_ENABLE_GEN_PHASE_EN
    logic [ACC_W-1:0] shadow_phase;
    always_ff @(posedge refclk)
      if (!rst_n) shadow_phase <= '0;
      else if (hit && cfg_sel) shadow_phase <= cfg_data;
    assign load = shadow_phase;
`else
    assign load = '0;
`endif
    // locked_next is already low on an apply edge, so this also clears ce on apply
    always_ff @(posedge refclk)
      if (!rst_n) begin
        shadow_inc <= '0;
        active_inc <= '0;
        acc <= '0;
        ce_q <= 1'b0;
      end else begin
        if (hit && !cfg_sel) shadow_inc <= cfg_data;
        active_inc <= cfg_apply ? shadow_inc : active_inc;
        acc <= cfg_apply ? load : sum[ACC_W-1:0];
        ce_q <= sum[ACC_W] & locked_next;
      end
    assign ce[i] = ce_q;
    assign outclk[i] = acc[ACC_W-1];
  end
endmodule
